vector_sweep_checker: RTL and testbench
=======================================

# vector_sweep_checker

Parametrised, self-checking exhaustive stimulus engine for small combinational lab designs. It sweeps every N_IN-bit input vector into a device under test and waits a programmable settle time per vector. It then compares the DUT output against a truth-table parameter and records a sticky error flag, a saturating mismatch count and the first failing vector. It sits beside the lab DUT in the board top level and replaces a hand-written simulation-only vector list with synthesizable, reusable hardware.

## Interface
- N_IN, 3: DUT input width; sweeps 2^N_IN vectors.
- TRUTH, 8'h8C: 2^N_IN-bit expected output table; bit i is the expected output for stim == i. The default encodes F = ~A&B | B&C with stim = {A,B,C}.
- SETTLE, 2: WAIT cycles per vector before sampling; legal range ≥ 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle request to begin a sweep.
- stop  in  1  abort the active sweep.
- loop  in  1  1 = restart from vector 0 after the last vector; sampled at each last-vector CHECK.
- observe  in  1  DUT output.
- stim  out  N_IN  vector driven to the DUT.
- expected  out  1  TRUTH[stim], combinational.
- busy  out  1  high in WAIT or CHECK.
- done  out  1  sweep completed; level output.
- err  out  1  sticky: one or more mismatches since the last start.
- err_count  out  N_IN+1  mismatch count, saturating at all-ones.
- first_fail_vec  out  N_IN  stim value at the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- Reset (asynchronous): state = IDLE; stim, busy, done, err, err_count, first_fail_vec and first_fail_valid all 0.
- IDLE or DONE, start = 1 and stop = 0:
  - Clear err, err_count, first_fail_vec, first_fail_valid and done.
  - stim ← 0, settle counter ← 0, go to WAIT.
- start is ignored while busy.
- WAIT: counter increments each cycle; at counter == SETTLE-1, go to CHECK.
- CHECK (exactly one cycle), comparing observe against TRUTH[stim]:
  - On mismatch: err ← 1; err_count increments unless it is all-ones.
  - On a mismatch with first_fail_valid = 0: first_fail_vec ← stim, first_fail_valid ← 1.
  - If stim == 2^N_IN-1 and loop = 1: stim ← 0, go to WAIT. Results accumulate; done stays 0.
  - If stim == 2^N_IN-1 and loop = 0: go to DONE.
  - Otherwise: stim ← stim+1, counter ← 0, go to WAIT.
- stop = 1 in WAIT or CHECK:
  - Next state is IDLE and stim ← 0; stop has priority over the CHECK transition.
  - The comparison in that cycle is still recorded.
  - err, err_count and first_fail_* hold; done stays 0.
- stop and start both 1 in IDLE or DONE: stop wins and the state is unchanged.
- DONE: done = 1, stim holds 2^N_IN-1, results hold until the next start or reset.

## Timing
- Per-vector period: SETTLE+1 cycles. Full sweep: 2^N_IN·(SETTLE+1) cycles (24 for the defaults).
- busy rises and stim = 0 on the edge that samples start.
- done rises on the edge after the final CHECK, 2^N_IN·(SETTLE+1) edges after the start edge. busy falls on the same edge.
- observe is sampled on the edge that ends the CHECK cycle.
- stim changes only on the edge leaving CHECK, so the DUT sees a stable vector for SETTLE+1 cycles.
- Reset asserted mid-sweep clears every output immediately, without waiting for clk.

## Structure
- Shared header vsc_defs.vh holds:
  - state encodings VSC_IDLE/WAIT/CHECK/DONE as 2-bit localparams;
  - the default TRUTH constant for the current lab function.
- One sub-module, sweep_counter, contains the stim register, the settle counter, and the last-vector and settle-expired terminal flags. The FSM and result registers live in the top module.

## Test plan
- Reset with all inputs 0: every output 0; stim stays 0 for 10 cycles with no start.
- Defaults, observe tied to expected, start pulse: done at +24 edges, err = 0, err_count = 0, first_fail_valid = 0.
- observe = expected except inverted while stim == 3'b101: err = 1, err_count = 1, first_fail_vec = 3'b101.
- observe stuck at 0:
  - Mismatches occur at vectors 2, 3 and 7.
  - err_count = 3, first_fail_vec = 3'b010.
  - A second start clears the results at its edge, then the sweep reproduces the same values.
- loop = 1, observe stuck at 0, stop asserted at +50 edges (vector 0 of the third pass): err_count = 6, done = 0, busy = 0 and stim = 0 on the next edge.
- rst pulsed mid-sweep at vector 4 after a mismatch on vector 2: all outputs 0 immediately; a start issued after release performs a clean full sweep.

Source files
------------

// File: rtl/vector_sweep_checker_pkg.sv
// Shared definitions for the exhaustive vector sweep checker: FSM state
// encodings and the truth table of the current lab function.
package vector_sweep_checker_pkg;

    localparam logic [1:0] VSC_IDLE  = 2'd0;
    localparam logic [1:0] VSC_WAIT  = 2'd1;
    localparam logic [1:0] VSC_CHECK = 2'd2;
    localparam logic [1:0] VSC_DONE  = 2'd3;

    // F = ~A&B | B&C with stim = {A,B,C}; bit i is the output for stim == i.
    localparam logic [7:0] VSC_TRUTH_DEFAULT = 8'h8C;

    typedef enum logic [1:0] {
        ST_IDLE  = VSC_IDLE,
        ST_WAIT  = VSC_WAIT,
        ST_CHECK = VSC_CHECK,
        ST_DONE  = VSC_DONE
    } vsc_state_e;

endpackage

// File: rtl/vector_sweep_checker_sweep_counter.sv
// Stimulus vector register plus per-vector settle counter, with the
// last-vector and settle-expired terminal flags used by the sweep FSM.
module sweep_counter #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_advance,
    input  logic            i_tick,
    output logic [N_IN-1:0] o_stim,
    output logic            o_last,
    output logic            o_settled
);

    // One bit minimum so SETTLE == 1 still yields a legal counter.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    logic [N_IN-1:0] r_stim;
    logic [CW-1:0]   r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stim <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_stim <= '0;
            r_cnt  <= '0;
        end else if (i_advance) begin
            r_stim <= r_stim + 1'b1;
            r_cnt  <= '0;
        end else if (i_tick) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_stim    = r_stim;
    assign o_last    = (r_stim == '1);
    assign o_settled = (r_cnt == SETTLE_LAST);

endmodule

// File: rtl/vector_sweep_checker.sv
// Exhaustive stimulus engine: sweeps every N_IN-bit vector into a lab DUT,
// compares its output against TRUTH and records mismatch statistics.
module vector_sweep_checker
    import vector_sweep_checker_pkg::*;
#(
    parameter int                     N_IN   = 3,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = VSC_TRUTH_DEFAULT,
    parameter int                     SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            loop,
    input  logic            observe,
    output logic [N_IN-1:0] stim,
    output logic            expected,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    vsc_state_e      r_state;
    vsc_state_e      w_state_next;

    logic            w_clear;
    logic            w_advance;
    logic            w_tick;
    logic            w_check;
    logic            w_start;
    logic            w_mismatch;

    logic [N_IN-1:0] w_stim;
    logic            w_last;
    logic            w_settled;

    logic            r_err;
    logic [N_IN:0]   r_err_count;
    logic [N_IN-1:0] r_first_fail_vec;
    logic            r_first_fail_valid;

    sweep_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_sweep_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .i_tick    (w_tick),
        .o_stim    (w_stim),
        .o_last    (w_last),
        .o_settled (w_settled)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // stop outranks both start (when idle) and the CHECK transition.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        w_tick       = 1'b0;
        w_check      = 1'b0;
        w_start      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start && !stop) begin
                    w_start      = 1'b1;
                    w_clear      = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_settled) begin
                    w_state_next = ST_CHECK;
                end else begin
                    w_tick       = 1'b1;
                end
            end
            ST_CHECK: begin
                w_check = 1'b1;
                if (stop) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    if (loop) begin
                        w_clear      = 1'b1;
                        w_state_next = ST_WAIT;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_mismatch = (observe != TRUTH[w_stim]);

    // Results survive loop wrap and stop; only a fresh start or reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err              <= 1'b0;
            r_err_count        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
        end else if (w_start) begin
            r_err              <= 1'b0;
            r_err_count        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
        end else if (w_check && w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (!r_first_fail_valid) begin
                r_first_fail_vec   <= w_stim;
                r_first_fail_valid <= 1'b1;
            end
        end
    end

    assign stim             = w_stim;
    assign expected         = TRUTH[w_stim];
    assign busy             = (r_state == ST_WAIT) || (r_state == ST_CHECK);
    assign done             = (r_state == ST_DONE);
    assign err              = r_err;
    assign err_count        = r_err_count;
    assign first_fail_vec   = r_first_fail_vec;
    assign first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Table-driven bench for vector_sweep_checker with a per-vector scoreboard
// and hand-written sequences for stop, start/stop priority and async reset.
module tb_vector_sweep_checker;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int NVEC   = 1 << N_IN;
    localparam int PERIOD = NVEC * (SETTLE + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            stop;
    logic            loop;
    logic            observe;
    logic [N_IN-1:0] stim;
    logic            expected;
    logic            busy;
    logic            done;
    logic            err;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    always #5 clk = ~clk;

    vector_sweep_checker #(
        .N_IN   (N_IN),
        .TRUTH  (8'h8C),
        .SETTLE (SETTLE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .stop             (stop),
        .loop             (loop),
        .observe          (observe),
        .stim             (stim),
        .expected         (expected),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    // Golden lab function F = ~A&B | B&C, stim = {A,B,C}.
    function automatic logic ref_f(input logic [2:0] v);
        return (~v[2] & v[1]) | (v[1] & v[0]);
    endfunction

    // Modelled lab DUT: 0 good, 1 wrong at 5, 2 stuck 0, 3 stuck 1, 4 inverted.
    always_comb begin
        case (mode)
            1:       observe = ref_f(stim) ^ (stim == 3'd5);
            2:       observe = 1'b0;
            3:       observe = 1'b1;
            4:       observe = ~ref_f(stim);
            default: observe = ref_f(stim);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [N_IN-1:0] vec;
        logic            exp;
    } sb_t;

    sb_t sb_q[$];

    task automatic push_passes(input int passes, input int extra);
        sb_t e;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < NVEC; v++) begin
                e.vec = N_IN'(v);
                e.exp = ref_f(N_IN'(v));
                sb_q.push_back(e);
            end
        end
        for (int v = 0; v < extra; v++) begin
            e.vec = N_IN'(v);
            e.exp = ref_f(N_IN'(v));
            sb_q.push_back(e);
        end
    endtask

    // Each newly presented vector pops one scoreboard entry.
    logic [N_IN-1:0] prev_stim = '0;
    logic            prev_busy = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (busy === 1'b1 && (!prev_busy || stim != prev_stim)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=stim %0d required=no vector", stim);
            end else begin
                e = sb_q.pop_front();
                check("sb_stim", stim, e.vec);
                check("sb_expected", expected, e.exp);
            end
        end
        prev_busy = (busy === 1'b1);
        prev_stim = stim;
    end

    typedef struct {
        int              mode;
        int              passes;
        int              pulse_at;
        logic            exp_err;
        logic [N_IN:0]   exp_count;
        logic [N_IN-1:0] exp_ffv;
        logic            exp_valid;
    } vec_t;

    vec_t tbl[7];

    task automatic run_entry(input vec_t t, input int idx);
        int edges;
        mode  = t.mode;
        loop  = (t.passes > 1);
        push_passes(t.passes, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("e%0d_busy_rise", idx), busy, 1);
        check($sformatf("e%0d_stim_zero", idx), stim, 0);
        check($sformatf("e%0d_cleared", idx),
              {done, err, err_count, first_fail_vec, first_fail_valid}, 0);
        edges = 0;
        while (!done && edges < 400) begin
            start = (t.pulse_at != 0 && edges == t.pulse_at);
            if (edges == t.passes * PERIOD - 1) loop = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        loop  = 1'b0;
        check($sformatf("e%0d_done_edge", idx), edges, t.passes * PERIOD);
        check($sformatf("e%0d_busy_fall", idx), busy, 0);
        check($sformatf("e%0d_stim_last", idx), stim, NVEC - 1);
        check($sformatf("e%0d_err", idx), err, t.exp_err);
        check($sformatf("e%0d_err_count", idx), err_count, t.exp_count);
        check($sformatf("e%0d_ffv", idx), first_fail_vec, t.exp_ffv);
        check($sformatf("e%0d_ffvalid", idx), first_fail_valid, t.exp_valid);
        check($sformatf("e%0d_sb_empty", idx), sb_q.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {stim, busy, done, err, err_count, first_fail_vec, first_fail_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t clean;
        //            mode pass pulse err cnt   ffv   valid
        tbl[0] = '{0, 1, 0,  1'b0, 4'd0,  3'd0, 1'b0};
        tbl[1] = '{1, 1, 10, 1'b1, 4'd1,  3'd5, 1'b1};
        tbl[2] = '{2, 1, 0,  1'b1, 4'd3,  3'd2, 1'b1};
        tbl[3] = '{2, 1, 0,  1'b1, 4'd3,  3'd2, 1'b1};
        tbl[4] = '{3, 1, 0,  1'b1, 4'd5,  3'd0, 1'b1};
        tbl[5] = '{4, 2, 0,  1'b1, 4'd15, 3'd0, 1'b1};
        tbl[6] = '{0, 1, 0,  1'b0, 4'd0,  3'd0, 1'b0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle_stim_c%0d", i), {stim, busy}, 0);
        end

        for (int i = 0; i < 7; i++) begin
            run_entry(tbl[i], i);
            $display("entry %0d mode=%0d err=%0d count=%0d ffv=%0d valid=%0d",
                     i, tbl[i].mode, err, err_count, first_fail_vec, first_fail_valid);
        end

        // start together with stop in DONE leaves the state alone.
        mode = 2;
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        check("done_startstop_done", done, 1);
        check("done_startstop_busy", busy, 0);
        $display("start+stop in DONE: done=%0d busy=%0d", done, busy);

        // Looping sweep stopped during vector 0 of the third pass.
        mode = 2; loop = 1'b1;
        push_passes(2, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk); #1;
        check("stop_err_count", err_count, 6);
        check("stop_done", done, 0);
        check("stop_busy", busy, 0);
        check("stop_stim", stim, 0);
        check("stop_results_hold", {err, first_fail_vec, first_fail_valid}, {1'b1, 3'd2, 1'b1});
        check("stop_sb_empty", sb_q.size(), 0);
        start = 1'b1;
        @(posedge clk); #1;
        check("idle_startstop_busy", busy, 0);
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        $display("stop sequence: count=%0d busy=%0d stim=%0d", err_count, busy, stim);

        // Async reset during vector 4 after the vector 2 mismatch.
        mode = 2;
        push_passes(1, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre_reset_err", err, 1);
        check("pre_reset_stim", stim, 4);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset_outputs");
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        $display("async reset mid-sweep: all outputs cleared");
        clean = '{0, 1, 0, 1'b0, 4'd0, 3'd0, 1'b0};
        run_entry(clean, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
